// File: rtl/int_req_pkg.sv
// Shared types and constants for the interrupt requester.
package int_req_pkg;

  localparam int unsigned ID_W        = 3;
  localparam int unsigned MAX_SRC     = 8;
  localparam int unsigned DEF_HOLDOFF = 8;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    TOUT = 2'd3
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module int_prio_enc
  import int_req_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_requester.sv
// Edge-triggered interrupt requester with holdoff between grants.
// Optional ack timeout and timeout_err port enabled by INT_REQUESTER_TIMEOUT_EN.
module int_requester
  import int_req_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned HOLDOFF = DEF_HOLDOFF,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack,
  output logic               int_flag,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               overrun
`ifdef INT_REQUESTER_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  if (NUM_SRC < 1 || NUM_SRC > MAX_SRC || TIMEOUT < 1) begin : g_bad_cfg
    $error("int_requester: unsupported NUM_SRC or TIMEOUT");
  end

  state_t             state;
  logic [NUM_SRC-1:0] src_q;
  logic               ack_q;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] clr;
  logic               ack_rise;
  logic               ack_take;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

`ifdef INT_REQUESTER_TIMEOUT_EN
  localparam int unsigned TOUT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TOUT_W-1:0] tout_cnt;
`endif

  assign src_rise = src & ~src_q;
  assign ack_rise = ack & ~ack_q;
  assign ack_take = (state == REQ) && ack_rise;
  // A coincident new edge on the serviced source re-sets the bit via the OR below.
  assign clr      = ack_take ? (NUM_SRC'(1) << int_id) : '0;

  int_prio_enc #(.N(NUM_SRC)) u_enc (
    .req   (pending & mask),
    .valid (win_valid),
    .idx   (win_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      int_flag <= 1'b0;
      int_id   <= '0;
      pending  <= '0;
      overrun  <= 1'b0;
      hold_cnt <= '0;
      src_q    <= src;
      ack_q    <= ack;
`ifdef INT_REQUESTER_TIMEOUT_EN
      tout_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      src_q   <= src;
      ack_q   <= ack;
      pending <= (pending & ~clr) | src_rise;
      if (|(src_rise & pending & ~clr)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= REQ;
            int_flag <= 1'b1;
            int_id   <= win_id;
`ifdef INT_REQUESTER_TIMEOUT_EN
            tout_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (ack_rise) begin
            int_flag <= 1'b0;
            int_id   <= '0;
            if (HOLDOFF == 0) begin
              state <= IDLE;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(HOLDOFF - 1);
            end
          end
`ifdef INT_REQUESTER_TIMEOUT_EN
          else if (32'(tout_cnt) + 32'd1 >= TIMEOUT) begin
            state       <= TOUT;
            int_flag    <= 1'b0;
            int_id      <= '0;
            timeout_err <= 1'b1;
          end else begin
            tout_cnt <= tout_cnt + TOUT_W'(1);
          end
`endif
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        TOUT: begin
          // One dead cycle after a timeout, then a full holdoff.
          if (HOLDOFF == 0) begin
            state <= IDLE;
          end else begin
            state    <= HOLD;
            hold_cnt <= HOLD_W'(HOLDOFF - 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_requester.sv
// Randomized and directed bench for int_requester against a behavioural model.
// Define INT_REQUESTER_TIMEOUT_EN to also exercise the ack timeout.
module tb_int_requester;

  localparam int unsigned NSRC     = 4;
  localparam int unsigned HOLD_CYC = 8;
  localparam int unsigned TOUT_CYC = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            ack;
  logic [NSRC-1:0] src;
  logic [NSRC-1:0] mask;
  logic            int_flag;
  logic [2:0]      int_id;
  logic [NSRC-1:0] pending;
  logic            overrun;
`ifdef INT_REQUESTER_TIMEOUT_EN
  logic            timeout_err;
  localparam bit   TOUT_EN = 1'b1;
`else
  localparam bit   TOUT_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int_requester #(
    .NUM_SRC (NSRC),
    .HOLDOFF (HOLD_CYC),
    .TIMEOUT (TOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src      (src),
    .mask     (mask),
    .ack      (ack),
    .int_flag (int_flag),
    .int_id   (int_id),
    .pending  (pending),
    .overrun  (overrun)
`ifdef INT_REQUESTER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: request flag, quiet-time countdown before the next grant,
  // and age of the outstanding request.
  bit            m_flag;
  int            m_id;
  bit [NSRC-1:0] m_pend;
  bit            m_ovr;
  bit            m_terr;
  int            m_quiet;
  int            m_age;
  bit [NSRC-1:0] p_src;
  bit            p_ack;

  task automatic model_step();
    bit [NSRC-1:0] rise, clr, elig;
    bit            arise, found;
    if (reset) begin
      m_flag = 0; m_id = 0; m_pend = '0; m_ovr = 0; m_terr = 0;
      m_quiet = 0; m_age = 0; p_src = src; p_ack = ack;
      return;
    end
    rise  = src & ~p_src;
    arise = ack && !p_ack;
    clr   = '0;
    elig  = m_pend & mask;
    if (m_flag) begin
      if (arise) begin
        clr[m_id] = 1'b1;
        m_flag    = 0;
        m_id      = 0;
        m_quiet   = HOLD_CYC;
      end else if (TOUT_EN) begin
        m_age++;
        if (m_age >= TOUT_CYC) begin
          m_flag  = 0;
          m_id    = 0;
          m_terr  = 1;
          m_quiet = HOLD_CYC + 1;
        end
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (elig != '0) begin
      found = 0;
      for (int i = 0; i < NSRC; i++) begin
        if (!found && elig[i]) begin
          m_id  = i;
          found = 1;
        end
      end
      m_flag = 1;
      m_age  = 0;
    end
    if ((rise & m_pend & ~clr) != '0) m_ovr = 1;
    m_pend = (m_pend & ~clr) | rise;
    p_src  = src;
    p_ack  = ack;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, update the model, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("int_flag", 32'(int_flag), 32'(m_flag));
    check("int_id",   32'(int_id),   32'(m_id));
    check("pending",  32'(pending),  32'(m_pend));
    check("overrun",  32'(overrun),  32'(m_ovr));
`ifdef INT_REQUESTER_TIMEOUT_EN
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
`endif
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    src   = '0;
    mask  = '1;
    ack   = 1'b0;

    do_reset();
    check("rst_flag", 32'(int_flag), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);

    // Single pulse on src0: pending next edge, flag one edge later.
    src = 4'b0001;
    cycle();
    check("pulse_pend", 32'(pending), 32'd1);
    check("pulse_flag_lo", 32'(int_flag), 32'd0);
    src = 4'b0000;
    cycle();
    check("pulse_flag", 32'(int_flag), 32'd1);
    check("pulse_id", 32'(int_id), 32'd0);
    ack_pulse();
    cycles(HOLD_CYC + 3);

    // Two simultaneous edges: lowest first, next only after holdoff.
    src = 4'b1010;
    cycles(2);
    check("two_id1", 32'(int_id), 32'd1);
    ack_pulse();
    cycles(HOLD_CYC);
    check("two_gap", 32'(int_flag), 32'd0);
    cycle();
    check("two_flag3", 32'(int_flag), 32'd1);
    check("two_id3", 32'(int_id), 32'd3);
    ack_pulse();
    src = 4'b0000;
    cycles(HOLD_CYC + 3);

    // ack high through reset must not count as an edge.
    ack = 1'b1;
    do_reset();
    src = 4'b0001;
    cycles(6);
    check("ackrst_hold", 32'(int_flag), 32'd1);
    ack = 1'b0;
    cycle();
    ack_pulse();
    check("ackrst_drop", 32'(int_flag), 32'd0);
    src = 4'b0000;
    cycles(HOLD_CYC + 3);

    // Source edge coinciding with its own ack: pending kept, no overrun.
    src = 4'b0001;
    cycle();
    src = 4'b0000;
    cycles(2);
    src = 4'b0001;
    ack = 1'b1;
    cycle();
    check("coin_pend", 32'(pending[0]), 32'd1);
    check("coin_ovr", 32'(overrun), 32'd0);
    src = 4'b0000;
    ack = 1'b0;
    cycles(HOLD_CYC + 1);
    check("coin_rereq", 32'(int_flag), 32'd1);
    src = 4'b0001;
    cycle();
    check("coin_ovr_set", 32'(overrun), 32'd1);
    src = 4'b0000;
    ack_pulse();
    cycles(HOLD_CYC + 3);

    // Masked source keeps pending; mask change in REQ has no effect.
    do_reset();
    mask = 4'b1110;
    src  = 4'b0101;
    cycles(2);
    check("mask_id2", 32'(int_id), 32'd2);
    check("mask_pend0", 32'(pending[0]), 32'd1);
    mask = 4'b1111;
    cycles(3);
    check("mask_stay", 32'(int_id), 32'd2);
    ack_pulse();
    cycles(HOLD_CYC + 1);
    check("mask_id0", 32'(int_id), 32'd0);
    ack_pulse();
    src = 4'b0000;
    cycles(HOLD_CYC + 3);

`ifdef INT_REQUESTER_TIMEOUT_EN
    // Withheld ack: drop after the timeout, keep pending, re-request later.
    do_reset();
    src = 4'b0001;
    cycle();
    src = 4'b0000;
    cycles(TOUT_CYC + 1);
    check("tout_drop", 32'(int_flag), 32'd0);
    check("tout_err", 32'(timeout_err), 32'd1);
    check("tout_pend", 32'(pending[0]), 32'd1);
    cycles(HOLD_CYC + 2);
    check("tout_rereq", 32'(int_flag), 32'd1);
    ack_pulse();
    cycles(HOLD_CYC + 3);
`endif

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) src = NSRC'($urandom);
      if ($urandom_range(0, 15) == 0) mask = NSRC'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 127) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
